// File: rtl/wdt_ctrl_if.sv
// Read-side handshake between the WDT-domain command FIFO and the watchdog controller.
// master = controller (issues pops), slave = FIFO (supplies empty flag and data).
interface wdt_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  localparam int CMD_WIDTH = CNT_WIDTH + 2;

  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [CMD_WIDTH-1:0] fifo_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_pop
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_pop
  );
endinterface

// File: rtl/wdt_ctrl.sv
// Watchdog controller: pops one command at a time from the CDC FIFO, applies it,
// and runs the timeout counter that drives the level timeout flag.
module wdt_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  wdt_ctrl_if.master           fifo,
  output logic                 wdt_en,
  output logic                 wto,
  output logic [CNT_WIDTH-1:0] cnt
);
  localparam int CMD_WIDTH = CNT_WIDTH + 2;

  localparam logic [1:0] OP_ENABLE = 2'b00;
  localparam logic [1:0] OP_KICK   = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t               state_q;
  logic                 wdt_en_q;
  logic                 wto_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] tocnt_q;

  logic [1:0]           op;
  logic [CNT_WIDTH-1:0] val;
  logic                 cmd_apply;

  assign op  = fifo.fifo_data[CMD_WIDTH-1:CNT_WIDTH];
  assign val = fifo.fifo_data[CNT_WIDTH-1:0];

  // Reserved opcode is consumed but counts as "no command", so the counter keeps running.
  assign cmd_apply = (state_q == EXEC) && (op != 2'b11);

  // Pop is held low during reset even though the state already reads IDLE.
  assign fifo.fifo_pop = rstn && (state_q == IDLE) && !fifo.fifo_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wdt_en_q <= 1'b0;
      wto_q    <= 1'b0;
      cnt_q    <= '0;
      tocnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (!fifo.fifo_empty) state_q <= EXEC;
        EXEC: state_q <= IDLE;
      endcase

      if (cmd_apply) begin
        case (op)
          OP_ENABLE: begin
            wdt_en_q <= val[0];
            cnt_q    <= '0;
            wto_q    <= 1'b0;
          end
          OP_KICK: begin
            cnt_q <= '0;
            wto_q <= 1'b0;
          end
          OP_LOAD: begin
            tocnt_q <= val;
            cnt_q   <= '0;
          end
          default: ;
        endcase
      end else if (wdt_en_q && !wto_q) begin
        // Compare before increment so cnt never passes tocnt and cannot wrap.
        if (cnt_q == tocnt_q) wto_q <= 1'b1;
        else                  cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign wdt_en = wdt_en_q;
  assign wto    = wto_q;
  assign cnt    = cnt_q;
endmodule

// File: doc/wdt_ctrl.md
# wdt_ctrl

Watchdog control and counter stage in the WDT clock domain. Sits directly downstream of the 2-entry async command FIFO that carries register writes from the bus domain. Pops one command at a time, applies it (enable, kick, timeout load) and runs the timeout counter. Drives the level-type watchdog timeout `wto`.

## Interface
Parameters:
- `CNT_WIDTH`, 32, width of the timeout value and the counter.
- `CMD_WIDTH`, `CNT_WIDTH+2`, localparam, not overridable; command word width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: WDT domain clock.
- `rstn` in 1: asynchronous active-low reset.
- `fifo_empty` in 1: FIFO read-side empty flag.
- `fifo_pop` out 1: FIFO read request.
- `fifo_data` in `CMD_WIDTH`: FIFO registered read data. Valid from the edge that completes a pop.
- `wdt_en` out 1: watchdog enabled.
- `wto` out 1: timeout flag, level.
- `cnt` out `CNT_WIDTH`: current counter value, for debug and status.

## Operation
- Command format: `fifo_data[CMD_WIDTH-1:CNT_WIDTH]` is `op`; `fifo_data[CNT_WIDTH-1:0]` is `val`.
  - op 2'b00 ENABLE: `wdt_en <= val[0]`; `cnt <= 0`; `wto <= 0`.
  - op 2'b01 KICK: `cnt <= 0`; `wto <= 0`; `val` ignored. Applies whether enabled or not.
  - op 2'b10 LOAD: `tocnt <= val`; `cnt <= 0`; `wto` unchanged.
  - op 2'b11: reserved. No state change, but the command is still consumed.
- FSM states: IDLE, EXEC.
  - IDLE: `fifo_pop = !fifo_empty`, combinational. If `!fifo_empty` → EXEC, else stay.
  - EXEC: `fifo_pop = 0`. Decode `fifo_data` and apply it at the edge leaving EXEC → IDLE.
  - Throughput: at most one command per 2 clocks.
- Counter, evaluated every edge when no command is applied at that edge:
  - `wdt_en=1`, `wto=0`, `cnt != tocnt`: `cnt <= cnt+1`.
  - `wdt_en=1`, `wto=0`, `cnt == tocnt`: `wto <= 1`; `cnt` holds.
  - `wto=1`: `cnt` holds; `wto` stays 1 until ENABLE or KICK.
  - `wdt_en=0`: `cnt` holds.
- Arithmetic: `cnt` and `tocnt` are unsigned `CNT_WIDTH`. `cnt` never exceeds `tocnt` while enabled, so it cannot wrap. `tocnt = 2^CNT_WIDTH-1` is legal.
- Simultaneous command and counter event: the command has priority. A KICK at the edge where `cnt == tocnt` clears `cnt`, and `wto` is not set.
- LOAD with `val < cnt` while enabled: `cnt` is cleared by the LOAD, so there is no underflow.

## Timing
- Reset values (asynchronous): state IDLE, `wdt_en=0`, `wto=0`, `cnt=0`, `tocnt=0`. `fifo_pop` is forced to 0 while `rstn=0`.
- Reset mid-operation: a command popped but not yet applied (state EXEC) is lost. All outputs return to reset values immediately.
- Pop to effect:
  - Edge T0: `fifo_pop=1` and `fifo_empty=0` sampled; FIFO updates `fifo_data`.
  - Edge T1: command applied; outputs reflect it after T1.
- Timeout latency: the ENABLE(1) or KICK applies at edge E with `tocnt=N`. `cnt` is then 0,1..N on edges E..E+N. `wto` rises at edge E+N+1.
  - With N=0, `wto` rises at E+1.
- `fifo_pop` is never asserted in EXEC. Back-to-back commands are spaced by 2 clocks.

## Test plan
- Reset with FIFO non-empty:
  - Stimulus: hold `rstn=0` with `fifo_empty=0`.
  - Required: `fifo_pop=0`, `wdt_en=0`, `wto=0`, `cnt=0`.
  - After release: first pop on the first edge.
- Basic timeout:
  - Stimulus: LOAD 5, then ENABLE 1 applied at edge E.
  - Required: `cnt` goes 0..5 on E..E+5; `wto=1` after E+6; `cnt` holds 5.
- Kick race:
  - Stimulus: tocnt=3; KICK applied exactly at the edge where `cnt==3`.
  - Required: `wto` stays 0, `cnt=0`. Timeout then occurs 4 edges later.
- Clear timeout:
  - Stimulus: with `wto=1`, send KICK; then send ENABLE 0.
  - Required: `wto=0` and counting restarts from 0 after the KICK. After ENABLE 0, `wdt_en=0`, `cnt` frozen at 0, and `wto` never asserts.
- Command stream:
  - Stimulus: 4 commands back-to-back (LOAD 2, reserved op 2'b11, ENABLE 1, KICK), with `fifo_empty` kept low.
  - Required: `fifo_pop` pulses every 2nd clock, exactly 4 pops. The reserved op causes no state change. Final `tocnt=2`, `wdt_en=1`, `cnt=0`.
- Edge values:
  - Stimulus: LOAD 0 with ENABLE 1.
  - Required: `wto` rises 1 edge after the enable.
  - Stimulus: LOAD `2^CNT_WIDTH-1`.
  - Required: the counter runs without wrap; checked with a reduced `CNT_WIDTH=4`.
